// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit switch synchronizer and debouncer feeding the PIO in_port.
// Optional change pulses are built only when SW_DEBOUNCE_CHANGE_PULSE_EN is defined.
module sw_debounce #(
    parameter int               WIDTH           = 16,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_changed
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_LEVEL;
            end
        end else begin
            sync_q[0] <= sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync[i] != sw_stable[i]) && (cnt[i] == LAST);
        end
    end

    // Any return to the stable level clears progress, so glitches never accumulate.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_stable <= RESET_LEVEL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == sw_stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    cnt[i]       <= '0;
                    sw_stable[i] <= sync[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_changed <= '0;
        end else begin
            sw_changed <= accept;
        end
    end
`else
    assign sw_changed = '0;
`endif

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Per-bit synchronizer and debouncer for the 16 board slide switches. It sits directly upstream of the switch PIO input port. Raw, asynchronous, bouncing switch levels enter on `sw_raw`. The block emits clean, clock-synchronous `sw_stable` levels, which drive the PIO `in_port`, plus optional one-cycle change pulses. This keeps Nios software free of switch bounce.

## Interface
- `WIDTH`, 16, number of independent switch bits.
- `SYNC_STAGES`, 2, flip-flops in each bit's metastability chain; legal range 2..4.
- `DEBOUNCE_CYCLES`, 50000, consecutive cycles a new level must persist before acceptance (1 ms at 50 MHz); legal range 2..2^20.
- `RESET_LEVEL`, 0, value loaded into every sync stage and every `sw_stable` bit on reset (WIDTH bits).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `sw_raw`  in  WIDTH  asynchronous raw switch levels.
- `sw_stable`  out  WIDTH  debounced levels; connects to the PIO `in_port`.
- `sw_changed`  out  WIDTH  one-cycle pulse per bit when that bit's `sw_stable` changes (see Configuration).

## Operation
- Each bit is fully independent: its own sync chain, its own counter of width clog2(DEBOUNCE_CYCLES), and its own stable register. There is no shared state between bits.
- Sync chain: `sw_raw[i]` shifts through SYNC_STAGES registers. The last stage is `sync[i]`.
- Per-bit counter behaviour, evaluated each cycle:
  - `sync[i] == sw_stable[i]`: counter is set to 0.
  - `sync[i] != sw_stable[i]` and counter < DEBOUNCE_CYCLES-1: counter increments by 1.
  - `sync[i] != sw_stable[i]` and counter == DEBOUNCE_CYCLES-1: `sw_stable[i]` is set to `sync[i]`, counter is set to 0, and `sw_changed[i]` is 1 for the next cycle.
- Any return of `sync[i]` to the stable level before acceptance discards progress; the counter goes to 0. A glitch shorter than DEBOUNCE_CYCLES never reaches `sw_stable`.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Simultaneous changes on several bits are accepted independently, in the same cycle if their counters expire together.
- Effective states per bit:
  - IDLE (match, counter 0).
  - PENDING (mismatch, counter counting).
  - Accept in PENDING returns to IDLE.
- Reset:
  - Sync stages and `sw_stable` load RESET_LEVEL.
  - Counters load 0.
  - `sw_changed` loads 0.
  - Reset asserted mid-PENDING abandons the pending change without producing a pulse.

## Timing
- All outputs are registered; there is no combinational path from `sw_raw` to any output.
- Reset values: `sw_stable` = RESET_LEVEL, `sw_changed` = 0.
- Latency: for a clean level change first sampled at edge k, `sw_stable` updates on edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. That is, it is visible after SYNC_STAGES+DEBOUNCE_CYCLES sampling edges.
- `sw_changed[i]` rises on the same edge that `sw_stable[i]` updates and falls on the following edge. It is exactly one cycle wide.
- A level must stay unchanged at `sync[i]` for DEBOUNCE_CYCLES consecutive cycles to be accepted. DEBOUNCE_CYCLES-1 cycles is rejected.
- Minimum spacing between two accepted changes on one bit is DEBOUNCE_CYCLES cycles.
- If reset is released while `sw_raw` differs from RESET_LEVEL, the new level is treated as a normal change. The pulse appears after the full latency.

## Configuration
- Macro `SW_DEBOUNCE_CHANGE_PULSE_EN`.
- Defined: `sw_changed` is generated as described, registered and one cycle wide per accepted change.
- Undefined:
  - `sw_changed` is tied to all zeros.
  - The pulse register is not built.
  - The port remains so that instantiation is identical in both builds.
  - `sw_stable` behaviour is unaffected.

## Test plan
All tests use WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0 unless noted.
- Reset: hold `reset` 3 cycles with `sw_raw`=16'hFFFF. Required: `sw_stable`=16'h0000 and `sw_changed`=0 throughout reset. After release, `sw_stable`=16'hFFFF exactly 6 edges later, with a single `sw_changed`=16'hFFFF pulse.
- Clean edge: `sw_raw[0]` goes 0→1 at edge k. Required: `sw_stable[0]`=1 at edge k+5, not before. `sw_changed`=16'h0001 for exactly one cycle.
- Glitch rejection:
  - `sw_raw[3]` goes high for 3 cycles, then low. Required: `sw_stable` stays 16'h0000 and `sw_changed` stays 0.
  - Repeat with 4 cycles high. Required: accepted, then a return to 0 after 4 further stable cycles, giving two pulses.
- Bounce: toggle `sw_raw[7]` every 2 cycles for 20 cycles, then hold 1. Required: `sw_stable[7]` changes exactly once, 6 edges after the final transition.
- Multi-bit and reset mid-operation:
  - `sw_raw`=16'hA5A5 at once. Required: `sw_stable`=16'hA5A5 after 6 edges, with one `sw_changed`=16'hA5A5 pulse.
  - Assert `reset` 1 cycle while a change is PENDING. Required: no pulse; `sw_stable` returns to 16'h0000.
- Configuration build: compile without `SW_DEBOUNCE_CHANGE_PULSE_EN` and rerun the clean-edge test. Required: identical `sw_stable` timing; `sw_changed` constantly 16'h0000.
